// File: rtl/instruction_fetch_unit.sv
// Program loader plus fetch stage in front of a 64-word instruction memory.
// Optional backpressure counter is enabled with `define FETCH_STALL_COUNT_EN.
module instruction_fetch_unit #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  fault_o,
  output logic [31:0]           stall_count_o
);

  localparam int unsigned           PTR_W      = $clog2(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] MEM_BYTES  = DATA_WIDTH'(4 * MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] LIMIT_ADDR = BASE_ADDR + MEM_BYTES;
  localparam logic [DATA_WIDTH-1:0] LAST_ADDR  = LIMIT_ADDR - DATA_WIDTH'(4);
  localparam logic [PTR_W-1:0]      LAST_PTR   = PTR_W'(MEMORY_DEPTH - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_FETCH, ST_HALT} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [DATA_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic                    valid_q, valid_d;
  logic                    fault_q, fault_d;
  logic                    write_en;

  function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
    return (pc == LAST_ADDR) ? BASE_ADDR : pc + DATA_WIDTH'(4);
  endfunction

  function automatic logic target_ok(input logic [DATA_WIDTH-1:0] t);
    return (t[1:0] == 2'b00) && (t >= BASE_ADDR) && (t < LIMIT_ADDR);
  endfunction

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    load_ready_o = 1'b0;
    write_en     = 1'b0;
    Write_Data_o = '0;
    Address_o    = pc_q;
    case (state_q)
      ST_LOAD: begin
        load_ready_o = 1'b1;
        Address_o    = BASE_ADDR + DATA_WIDTH'({ptr_q, 2'b00});
        Write_Data_o = load_data_i;
        write_en     = load_valid_i;
        valid_d      = 1'b0;
        if (load_valid_i) begin
          ptr_d = ptr_q + PTR_W'(1);
          // The last memory slot ends loading even without load_last_i.
          if (load_last_i || (ptr_q == LAST_PTR)) begin
            state_d = ST_FETCH;
            pc_d    = BASE_ADDR;
          end
        end
      end
      ST_FETCH: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          valid_d = 1'b0;
          if (!target_ok(redirect_pc_i)) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end else if (!valid_q || instr_ready_i) begin
          instr_d  = Instruction_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = next_pc(pc_q);
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      ptr_q    <= '0;
      pc_q     <= BASE_ADDR;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  // Memory must never see a write while reset is held, even in LOAD.
  assign Write_Enable_o = write_en & rst_n;
  assign instr_o        = instr_q;
  assign pc_o           = pc_out_q;
  assign instr_valid_o  = valid_q;
  assign fault_o        = fault_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_FETCH) && valid_q && !instr_ready_i && !redirect_i) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count_o = stall_q;
`else
  assign stall_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: transaction-level model with per-cycle compare
// plus directed literal checks of loading, fetch, stall, redirect, fault and reset.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid_i, load_last_i, load_ready_o;
  logic [31:0] load_data_i;
  logic        Write_Enable_o;
  logic [31:0] Write_Data_o, Address_o, Instruction_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o, pc_o;
  logic        instr_valid_o, instr_ready_i, fault_o;
  logic [31:0] stall_count_o;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_last_i(load_last_i),
    .load_ready_o(load_ready_o),
    .Write_Enable_o(Write_Enable_o), .Write_Data_o(Write_Data_o), .Address_o(Address_o),
    .Instruction_i(Instruction_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .fault_o(fault_o), .stall_count_o(stall_count_o)
  );

  // Instruction memory: combinational read, synchronous write.
  logic [31:0] mem [64];
  logic [5:0]  mem_idx;
  assign mem_idx       = 6'((Address_o - BASE) >> 2);
  assign Instruction_i = mem[mem_idx];
  always @(posedge clk) if (Write_Enable_o) mem[mem_idx] <= Write_Data_o;

  // Reference model: program image plus fetch bookkeeping.
  logic [31:0] gold [64];
  int          m_state;  // 0 loading, 1 fetching, 2 halted
  int          m_ptr;
  logic [31:0] m_pc, m_instr, m_pcout, m_stall;
  logic        m_valid, m_fault;

  function automatic logic bad_target(input logic [31:0] t);
    return (t[1:0] != 2'b00) || (t < BASE) || (t >= BASE + 32'd256);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state <= 0; m_ptr <= 0; m_pc <= BASE; m_valid <= 1'b0;
      m_instr <= '0; m_pcout <= '0; m_fault <= 1'b0; m_stall <= '0;
    end else if (m_state == 0) begin
      if (load_valid_i) begin
        gold[m_ptr] <= load_data_i;
        m_ptr <= m_ptr + 1;
        if (load_last_i || m_ptr == 63) begin
          m_state <= 1;
          m_pc    <= BASE;
        end
      end
    end else if (m_state == 1) begin
      if (redirect_i) begin
        m_valid <= 1'b0;
        m_pc    <= redirect_pc_i;
        if (bad_target(redirect_pc_i)) begin
          m_fault <= 1'b1;
          m_state <= 2;
        end
      end else if (!m_valid || instr_ready_i) begin
        m_instr <= gold[6'((m_pc - BASE) >> 2)];
        m_pcout <= m_pc;
        m_valid <= 1'b1;
        m_pc    <= (m_pc == BASE + 32'd252) ? BASE : m_pc + 32'd4;
      end else begin
`ifdef FETCH_STALL_COUNT_EN
        if (m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
`endif
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m.valid", 32'(instr_valid_o), 32'(m_valid));
      if (m_valid) begin
        check("m.instr", instr_o, m_instr);
        check("m.pc", pc_o, m_pcout);
      end
      check("m.fault", 32'(fault_o), 32'(m_fault));
      check("m.ready", 32'(load_ready_o), 32'(m_state == 0));
      check("m.stall", stall_count_o, m_stall);
      check("m.addr", Address_o, (m_state == 0) ? BASE + 32'(4 * m_ptr) : m_pc);
      check("m.we", 32'(Write_Enable_o), 32'((m_state == 0) && load_valid_i && rst_n));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          nwr;
    logic [31:0] last_wa, prev_pc;
    bit          have_prev, wrapped;
    logic [31:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) gold[i] = '0;
    rst_n = 1'b0; load_valid_i = 1'b0; load_data_i = '0; load_last_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst.valid", 32'(instr_valid_o), 32'd0);
    check("rst.ready", 32'(load_ready_o), 32'd1);
    check("rst.fault", 32'(fault_o), 32'd0);
    check("rst.instr", instr_o, 32'd0);
    check("rst.pc", pc_o, 32'd0);
    check("rst.stall", stall_count_o, 32'd0);
    rst_n = 1'b1;
    instr_ready_i = 1'b1;

    // Four-word program, last flagged on the fourth.
    for (int i = 0; i < 4; i++) begin
      load_valid_i = 1'b1; load_data_i = words[i]; load_last_i = (i == 3);
      #1;
      check("ld.we", 32'(Write_Enable_o), 32'd1);
      check("ld.addr", Address_o, BASE + 32'(4 * i));
      @(posedge clk); #1;
    end
    load_valid_i = 1'b0; load_last_i = 1'b0;
    check("ld.valid0", 32'(instr_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("f.instr", instr_o, words[i]);
      check("f.pc", pc_o, BASE + 32'(4 * i));
    end

    // Backpressure for five cycles.
    instr_ready_i = 1'b0;
    repeat (5) tick();
    check("st.instr", instr_o, 32'h44);
    check("st.pc", pc_o, 32'h0040_000C);
    check("st.valid", 32'(instr_valid_o), 32'd1);
`ifdef FETCH_STALL_COUNT_EN
    check("st.count", stall_count_o, 32'd5);
`else
    check("st.count", stall_count_o, 32'd0);
`endif

    // Aligned in-range redirect.
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0020; instr_ready_i = 1'b1;
    tick();
    check("rd.drop", 32'(instr_valid_o), 32'd0);
    redirect_i = 1'b0;
    tick();
    check("rd.valid", 32'(instr_valid_o), 32'd1);
    check("rd.pc", pc_o, 32'h0040_0020);
    tick();
    check("rd.pc2", pc_o, 32'h0040_0024);

    // Misaligned redirect halts; further redirects ignored.
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0022;
    tick();
    check("flt.fault", 32'(fault_o), 32'd1);
    check("flt.valid", 32'(instr_valid_o), 32'd0);
    redirect_pc_i = 32'h0040_0010;
    repeat (3) tick();
    check("halt.valid", 32'(instr_valid_o), 32'd0);
    check("halt.ready", 32'(load_ready_o), 32'd0);
    redirect_i = 1'b0;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2.fault", 32'(fault_o), 32'd0);
    check("rst2.ready", 32'(load_ready_o), 32'd1);

    // Reset in the middle of a load restarts the pointer.
    for (int i = 0; i < 3; i++) begin
      load_valid_i = 1'b1; load_data_i = 32'hA1 + 32'(i); load_last_i = 1'b0;
      tick();
    end
    rst_n = 1'b0; load_data_i = 32'hDEAD;
    #1;
    check("rst3.we", 32'(Write_Enable_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; load_data_i = 32'hB0; load_last_i = 1'b1;
    #1;
    check("rl.addr", Address_o, BASE);
    check("rl.we", 32'(Write_Enable_o), 32'd1);
    @(posedge clk); #1;
    load_valid_i = 1'b0; load_last_i = 1'b0;
    tick();
    check("rl.instr0", instr_o, 32'hB0);
    check("rl.pc0", pc_o, BASE);
    tick();
    check("rl.instr1", instr_o, 32'hA2);

    // Overlong stream: only 64 words written, then PC wraps.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nwr = 0; last_wa = '0;
    for (int i = 0; i < 70; i++) begin
      load_valid_i = 1'b1; load_data_i = 32'h1000 + 32'(i); load_last_i = 1'b0;
      #1;
      if (Write_Enable_o) begin
        nwr++;
        last_wa = Address_o;
      end
      @(posedge clk); #1;
    end
    load_valid_i = 1'b0;
    check("ovf.writes", 32'(nwr), 32'd64);
    check("ovf.lastaddr", last_wa, 32'h0040_00FC);
    have_prev = 1'b0; wrapped = 1'b0; prev_pc = '0;
    for (int i = 0; i < 200; i++) begin
      if (instr_valid_o) begin
        if (pc_o == 32'h0040_00FC) check("wrap.top", instr_o, 32'h103F);
        if (have_prev && prev_pc == 32'h0040_00FC) begin
          check("wrap.pc", pc_o, BASE);
          check("wrap.instr", instr_o, 32'h1000);
          wrapped = 1'b1;
          break;
        end
        prev_pc = pc_o;
        have_prev = 1'b1;
      end
      tick();
    end
    check("wrap.seen", 32'(wrapped), 32'd1);

    // Out-of-range aligned target also faults.
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    tick();
    redirect_i = 1'b0;
    check("oor.fault", 32'(fault_o), 32'd1);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the 64-word instruction memory system and drives its write-enable, write-data and address inputs.
- After reset it runs as a program loader, streaming words from a host interface into memory.
- It then switches to fetch mode: it generates the PC, captures the returned instruction and presents it to decode over a valid/ready handshake.
- Memory read path is combinational (address to instruction, same cycle); memory write is synchronous on clk when write-enable is high.

Parameters:
- DATA_WIDTH, 32, instruction/data/address width.
- MEMORY_DEPTH, 64, number of 32-bit words in instruction memory.
- BASE_ADDR, 32'h0040_0000, byte address of memory word 0; PC reset value.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- load_valid_i  input  1  host has a program word.
- load_data_i  input  DATA_WIDTH  program word.
- load_last_i  input  1  current word is the final program word.
- load_ready_o  output  1  loader accepts a word this cycle.
- Write_Enable_o  output  1  to memory write enable.
- Write_Data_o  output  DATA_WIDTH  to memory write data.
- Address_o  output  DATA_WIDTH  to memory byte address.
- Instruction_i  input  DATA_WIDTH  from memory read data.
- redirect_i  input  1  branch/jump redirect request.
- redirect_pc_i  input  DATA_WIDTH  redirect target byte address.
- instr_o  output  DATA_WIDTH  registered instruction to decode.
- pc_o  output  DATA_WIDTH  byte address of instr_o.
- instr_valid_o  output  1  instr_o/pc_o valid.
- instr_ready_i  input  1  decode accepts instruction.
- fault_o  output  1  sticky misaligned-redirect fault.
- stall_count_o  output  32  backpressure counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a rising edge, including mid-load or mid-fetch):
  - State goes to LOAD, load pointer to 0, PC to BASE_ADDR.
  - instr_o, pc_o, instr_valid_o, fault_o and stall_count_o go to 0.
  - Write_Enable_o is 0 while rst_n=0.
- States: LOAD, FETCH, HALT.
- LOAD state:
  - load_ready_o=1.
  - Address_o = BASE_ADDR + 4*ptr.
  - Write_Data_o = load_data_i.
  - Write_Enable_o = load_valid_i (combinational).
  - On each accepted word, ptr increments.
  - Transition to FETCH, with PC=BASE_ADDR, when the accepted word has load_last_i=1 or ptr==MEMORY_DEPTH-1; words beyond depth are never written.
  - instr_valid_o=0 throughout LOAD.
- FETCH state:
  - load_ready_o=0, Write_Enable_o=0, Address_o=PC.
  - The output register advances when instr_valid_o=0 or (instr_valid_o & instr_ready_i). On advance: instr_o<=Instruction_i, pc_o<=PC, instr_valid_o<=1, PC<=PC+4.
  - Latency is 1 cycle from PC presentation to instr_valid_o. Throughput is 1 instruction per cycle under continuous ready.
  - When instr_valid_o=1 and instr_ready_i=0: instr_o, pc_o and PC hold.
- Wrap-around: a PC increment from BASE_ADDR+4*(MEMORY_DEPTH-1) yields BASE_ADDR.
- Redirect (FETCH only, highest priority, overrides advance and stall):
  - Next cycle: PC<=redirect_pc_i and instr_valid_o<=0; the in-flight instruction is dropped.
  - The first redirected instruction is valid 2 cycles after redirect_i.
  - If redirect_pc_i[1:0]!=0 or the target is outside [BASE_ADDR, BASE_ADDR+4*MEMORY_DEPTH): fault_o<=1, state HALT.
- HALT state:
  - instr_valid_o=0, load_ready_o=0, Write_Enable_o=0, Address_o=PC.
  - redirect_i and the load interface are ignored; exit only via reset.
- Simultaneous load_valid_i in FETCH is ignored. redirect_i in LOAD is ignored.

Optional Feature:
- Macro: FETCH_STALL_COUNT_EN.
- Defined: stall_count_o increments by 1 on each FETCH cycle with instr_valid_o=1, instr_ready_i=0 and no redirect. It saturates at 32'hFFFF_FFFF and clears on reset.
- Not defined: the counter logic is absent and stall_count_o is constant 0.

Test Plan:
- Load 4 words (0x11,0x22,0x33,0x44, last on 4th) → Write_Enable_o high 4 cycles at addresses 0x0040_0000..0x0040_000C. Then instr_o=0x11,0x22,0x33,0x44 with pc_o 0x0040_0000..0x0040_000C, one per cycle with ready=1.
- Stream 70 words with load_last_i never set → only 64 writes, last at 0x0040_00FC. FETCH starts and the PC wraps from 0x0040_00FC to 0x0040_0000.
- Hold instr_ready_i=0 for 5 cycles with instr_valid_o=1 → instr_o/pc_o unchanged. stall_count_o=5 with the macro defined, 0 without.
- redirect_i with target 0x0040_0020 while valid is high → instr_valid_o=0 the next cycle, then pc_o=0x0040_0020 the following cycle.
- redirect_pc_i=0x0040_0022 → fault_o=1 and HALT, valid stays 0 under further redirects. rst_n=0 for one edge → fault_o=0, LOAD, load_ready_o=1.
- Assert rst_n=0 mid-load after 3 words → ptr restarts, and the next accepted word writes 0x0040_0000.
